// File: rtl/cva6_ptw_sv32_lite.sv
// Sv32 two-level page-table walker. It takes one TLB miss at a time, reads PTEs through a
// single-outstanding memory port, and then emits a one-cycle TLB update or a page-fault pulse.
module cva6_ptw_sv32_lite #(
    parameter int ASID_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [21:0]       satp_ppn_i,
    input  logic [ASID_W-1:0] asid_i,
    input  logic              miss_valid_i,
    output logic              miss_ready_o,
    input  logic [31:0]       miss_vaddr_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [33:0]       mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [31:0]       mem_rsp_data_i,
    output logic [62:0]       update_o,
    output logic              fault_o,
    output logic [31:0]       fault_vaddr_o
);

    // Handshakes: a request transfers on a cycle where mem_req_valid_o && mem_req_ready_i;
    // once valid is raised, the address holds until that transfer or until flush_i aborts it.
    // A miss transfers on a cycle where miss_valid_i && miss_ready_o && !flush_i.
    typedef enum logic [2:0] {
        S_IDLE, S_REQ1, S_WAIT1, S_REQ0, S_WAIT0, S_UPDATE, S_FAULT, S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [8:0]  asid_q, asid_d;
    logic [33:0] addr_q, addr_d;
    logic [61:0] payload_q, payload_d;
    logic [31:0] fault_vaddr_q, fault_vaddr_d;

    logic pte_invalid, pte_leaf, pte_misaligned;

    // V=0, or the reserved W-without-R encoding.
    assign pte_invalid    = !mem_rsp_data_i[0] || (!mem_rsp_data_i[1] && mem_rsp_data_i[2]);
    assign pte_leaf       = mem_rsp_data_i[1] || mem_rsp_data_i[3];
    assign pte_misaligned = (mem_rsp_data_i[19:10] != 10'd0);

    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        asid_d        = asid_q;
        addr_d        = addr_q;
        payload_d     = payload_q;
        fault_vaddr_d = fault_vaddr_q;

        case (state_q)
            S_IDLE: begin
                if (miss_valid_i && !flush_i) begin
                    vaddr_d = miss_vaddr_i;
                    asid_d  = 9'(asid_i);
                    addr_d  = {satp_ppn_i, miss_vaddr_i[31:22], 2'b00};
                    state_d = S_REQ1;
                end
            end
            S_REQ1, S_REQ0: begin
                if (mem_req_ready_i) begin
                    // An accepted request always gets a response, so a flush must drain it.
                    if (flush_i)              state_d = S_DRAIN;
                    else if (state_q == S_REQ1) state_d = S_WAIT1;
                    else                      state_d = S_WAIT0;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT1: begin
                if (flush_i) begin
                    state_d = mem_rsp_valid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rsp_valid_i) begin
                    if (pte_invalid || (pte_leaf && pte_misaligned)) begin
                        fault_vaddr_d = vaddr_q;
                        state_d       = S_FAULT;
                    end else if (pte_leaf) begin
                        payload_d = {1'b1, vaddr_q[31:12], asid_q, mem_rsp_data_i};
                        state_d   = S_UPDATE;
                    end else begin
                        addr_d  = {mem_rsp_data_i[31:10], vaddr_q[21:12], 2'b00};
                        state_d = S_REQ0;
                    end
                end
            end
            S_WAIT0: begin
                if (flush_i) begin
                    state_d = mem_rsp_valid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rsp_valid_i) begin
                    if (pte_invalid || !pte_leaf) begin
                        fault_vaddr_d = vaddr_q;
                        state_d       = S_FAULT;
                    end else begin
                        payload_d = {1'b0, vaddr_q[31:12], asid_q, mem_rsp_data_i};
                        state_d   = S_UPDATE;
                    end
                end
            end
            S_UPDATE, S_FAULT: state_d = S_IDLE;
            S_DRAIN: begin
                if (mem_rsp_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            vaddr_q       <= '0;
            asid_q        <= '0;
            addr_q        <= '0;
            payload_q     <= '0;
            fault_vaddr_q <= '0;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            asid_q        <= asid_d;
            addr_q        <= addr_d;
            payload_q     <= payload_d;
            fault_vaddr_q <= fault_vaddr_d;
        end
    end

    assign miss_ready_o    = (state_q == S_IDLE);
    assign mem_req_valid_o = (state_q == S_REQ1) || (state_q == S_REQ0);
    assign mem_req_addr_o  = addr_q;
    assign update_o        = {(state_q == S_UPDATE), payload_q};
    assign fault_o         = (state_q == S_FAULT);
    assign fault_vaddr_o   = fault_vaddr_q;

endmodule

// File: tb/tb_cva6_ptw_sv32_lite.sv
// Directed bench for the Sv32 walker: a table of complete walks served by a zero-wait memory,
// followed by hand-written flush, backpressure and mid-walk reset sequences.
module tb_cva6_ptw_sv32_lite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [21:0] satp = '0;
  logic [8:0]  asid = '0;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_vaddr = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [33:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [62:0] update;
  logic        fault;
  logic [31:0] fault_vaddr;

  int n_vec = 0;
  int n_err = 0;
  logic [61:0] last_payload = '0;
  logic [31:0] last_fv = '0;

  cva6_ptw_sv32_lite #(.ASID_W(9)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .satp_ppn_i(satp), .asid_i(asid),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_vaddr_i(miss_vaddr),
    .mem_req_valid_o(req_valid), .mem_req_ready_i(req_ready), .mem_req_addr_o(req_addr),
    .mem_rsp_valid_i(rsp_valid), .mem_rsp_data_i(rsp_data),
    .update_o(update), .fault_o(fault), .fault_vaddr_o(fault_vaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [21:0] satp;
    logic [31:0] vaddr;
    logic [8:0]  asid;
    logic [31:0] l1;
    logic [31:0] l0;
    logic [33:0] l1_addr;
    logic [33:0] l0_addr;
    int          nreq;
    int          lat;
    bit          upd;
    logic [62:0] exp_upd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_miss(input logic [21:0] s, input logic [31:0] va, input logic [8:0] a);
    satp = s; miss_vaddr = va; asid = a; miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check(name, {update[62], fault, miss_ready, req_valid}, 4'b0010);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, nreq;
    bit pend, done;
    logic [31:0] pdata;
    check($sformatf("v%0d_ready", idx), miss_ready, 1);
    start_miss(v.satp, v.vaddr, v.asid);
    cyc = 1; nreq = 0; pend = 0; done = 0; pdata = '0;
    while (!done && cyc <= 20) begin
      if (update[62] || fault) begin
        done = 1;
        rsp_valid = 1'b0;
        req_ready = 1'b0;
      end else begin
        rsp_valid = pend;
        rsp_data  = pdata;
        pend = 0;
        if (req_valid) begin
          nreq++;
          if (nreq == 1) check($sformatf("v%0d_l1_addr", idx), req_addr, v.l1_addr);
          if (nreq == 2) check($sformatf("v%0d_l0_addr", idx), req_addr, v.l0_addr);
          req_ready = 1'b1;
          pend = 1;
          pdata = (nreq == 1) ? v.l1 : v.l0;
        end else begin
          req_ready = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    check($sformatf("v%0d_event_cycle", idx), cyc, v.lat);
    check($sformatf("v%0d_nreq", idx), nreq, v.nreq);
    check($sformatf("v%0d_update", idx), update, v.upd ? v.exp_upd : {1'b0, last_payload});
    check($sformatf("v%0d_fault", idx), fault, v.upd ? 1'b0 : 1'b1);
    check($sformatf("v%0d_fault_vaddr", idx), fault_vaddr, v.upd ? last_fv : v.vaddr);
    if (v.upd) last_payload = v.exp_upd[61:0];
    else       last_fv = v.vaddr;
    tick();
    check($sformatf("v%0d_pulse_end", idx), {update[62], fault, miss_ready}, 3'b001);
    check($sformatf("v%0d_payload_hold", idx), update[61:0], last_payload);
  endtask

  initial begin
    // satp, vaddr, asid, l1 pte, l0 pte, l1 addr, l0 addr, nreq, latency, update?, expected update
    vecs[0] = '{22'h00080, 32'h12345000, 9'h001, 32'h00024001, 32'h000AB0CF, 34'h080120, 34'h090D14,
                2, 5, 1'b1, {1'b1, 1'b0, 20'h12345, 9'h001, 32'h000AB0CF}};
    vecs[1] = '{22'h00080, 32'h12345000, 9'h001, 32'h200000CF, 32'h0, 34'h080120, 34'h0,
                1, 3, 1'b1, {1'b1, 1'b1, 20'h12345, 9'h001, 32'h200000CF}};
    vecs[2] = '{22'h00080, 32'h12345000, 9'h001, 32'h00000C0F, 32'h0, 34'h080120, 34'h0,
                1, 3, 1'b0, 63'h0};
    vecs[3] = '{22'h00080, 32'h12345000, 9'h001, 32'h00000000, 32'h0, 34'h080120, 34'h0,
                1, 3, 1'b0, 63'h0};
    vecs[4] = '{22'h00080, 32'h12345000, 9'h001, 32'h00024001, 32'h00024001, 34'h080120, 34'h090D14,
                2, 5, 1'b0, 63'h0};
    vecs[5] = '{22'h00080, 32'h12345000, 9'h001, 32'h00000005, 32'h0, 34'h080120, 34'h0,
                1, 3, 1'b0, 63'h0};
    vecs[6] = '{22'h12345, 32'hFFC01ABC, 9'h1FF, 32'hFFFFFC01, 32'h00001009, 34'h12345FFC, 34'h3FFFFF004,
                2, 5, 1'b1, {1'b1, 1'b0, 20'hFFC01, 9'h1FF, 32'h00001009}};
    vecs[7] = '{22'h00080, 32'h12345000, 9'h001, 32'h00024001, 32'h000AB0CE, 34'h080120, 34'h090D14,
                2, 5, 1'b0, 63'h0};
    vecs[8] = '{22'h00001, 32'h80000123, 9'h0AA, 32'h00400009, 32'h0, 34'h001800, 34'h0,
                1, 3, 1'b1, {1'b1, 1'b1, 20'h80000, 9'h0AA, 32'h00400009}};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_ready", miss_ready, 1);
    check("reset_update", update, 0);
    check("reset_fault", fault, 0);
    check("reset_fault_vaddr", fault_vaddr, 0);
    check("reset_req_valid", req_valid, 0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Flush while idle: miss must not be accepted.
    flush = 1'b1;
    start_miss(22'h00080, 32'h12345000, 9'h001);
    flush = 1'b0;
    check_quiet("idle_flush_a");
    tick();
    check_quiet("idle_flush_b");

    // Flush in WAIT1, response three cycles later is drained.
    start_miss(22'h00080, 32'h12345000, 9'h001);
    check("w1f_req", req_valid, 1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("w1f_drain_busy", {miss_ready, update[62], fault}, 3'b000);
    tick();
    tick();
    check("w1f_still_busy", {miss_ready, update[62], fault}, 3'b000);
    rsp_valid = 1'b1; rsp_data = 32'h000AB0CF;
    tick();
    rsp_valid = 1'b0;
    check_quiet("w1f_idle");
    tick();
    check_quiet("w1f_no_pulse");

    // Flush in REQ1 without handshake aborts straight to idle.
    start_miss(22'h00080, 32'h12345000, 9'h001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_quiet("r1f_abort");

    // Flush in REQ1 with handshake must drain the response.
    start_miss(22'h00080, 32'h12345000, 9'h001);
    req_ready = 1'b1; flush = 1'b1;
    tick();
    req_ready = 1'b0; flush = 1'b0;
    check("r1f_hs_drain", {miss_ready, req_valid}, 2'b00);
    rsp_valid = 1'b1; rsp_data = 32'h000AB0CF;
    tick();
    rsp_valid = 1'b0;
    check_quiet("r1f_hs_idle");

    // Flush in WAIT0 together with the response: response discarded, no update.
    start_miss(22'h00080, 32'h12345000, 9'h001);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h00024001;
    tick();
    rsp_valid = 1'b0;
    check("w0f_l0_addr", req_addr, 34'h090D14);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h000AB0CF; flush = 1'b1;
    tick();
    rsp_valid = 1'b0; flush = 1'b0;
    check_quiet("w0f_idle");
    check("w0f_payload_hold", update[61:0], last_payload);
    tick();
    check_quiet("w0f_no_pulse");

    // Backpressure for four cycles, then reset while in WAIT0.
    start_miss(22'h00080, 32'h12345000, 9'h001);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_valid_%0d", i), req_valid, 1);
      check($sformatf("bp_addr_%0d", i), req_addr, 34'h080120);
      tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h00024001;
    tick();
    rsp_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_payload = '0;
    last_fv = '0;
    check_quiet("rst_idle");
    check("rst_update_zero", update, 0);
    check("rst_fault_vaddr_zero", fault_vaddr, 0);
    rsp_valid = 1'b1; rsp_data = 32'h000AB0CF;
    tick();
    rsp_valid = 1'b0;
    check_quiet("late_rsp_ignored");
    check("late_rsp_update", update, 0);

    // Walker is fully usable again after the mid-walk reset.
    run_vec(100, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
